// File: rtl/ca3_demux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ca3_demux_pkg : shared FSM state type and width constants.  Rev 1.0
// ---------------------------------------------------------------------------
package ca3_demux_pkg;

  localparam int N  = 16;
  localparam int SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : ca3_demux_pkg
`default_nettype wire

// File: rtl/ca3_demux_1to4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ca3_demux_1to4 : 1-to-4 one-hot decoder with enable.  Rev 1.0
// ---------------------------------------------------------------------------
module ca3_demux_1to4 (
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic [3:0] y_o
);

  always_comb begin
    y_o = 4'b0000;
    if (en_i) begin
      y_o[sel_i] = 1'b1;
    end
  end

endmodule : ca3_demux_1to4
`default_nettype wire

// File: rtl/ca3_serial_demux_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ca3_serial_demux_16 : serial-to-parallel bit demux, auto or addressed.  Rev 1.0
// ---------------------------------------------------------------------------
module ca3_serial_demux_16
  import ca3_demux_pkg::state_t, ca3_demux_pkg::IDLE, ca3_demux_pkg::RECV,
         ca3_demux_pkg::DONE, ca3_demux_pkg::SW;
#(
  parameter int N = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          din,
  input  logic          din_valid,
  input  logic          addr_mode,
  input  logic [SW-1:0] S,
  output logic [N-1:0]  A,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] cnt
);

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          busy_q;
  logic          done_q;

  logic          w_accept;
  logic [SW-1:0] w_idx;
  logic [3:0]    w_grp;
  logic [N-1:0]  w_we;

  assign w_accept = (state_q == RECV) && din_valid;
  assign w_idx    = addr_mode ? S : cnt_q;

  // Two-level tree: the root picks a nibble, each leaf picks the bit inside it.
  ca3_demux_1to4 u_root (
    .en_i  (w_accept),
    .sel_i (w_idx[3:2]),
    .y_o   (w_grp)
  );

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    ca3_demux_1to4 u_leaf (
      .en_i  (w_grp[g]),
      .sel_i (w_idx[1:0]),
      .y_o   (w_we[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          cnt_d   = '0;
          a_d     = '0;
        end
      end
      RECV: begin
        if (din_valid) begin
          a_d   = (a_q & ~w_we) | (w_we & {N{din}});
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == RECV);
      done_q  <= (state_d == DONE);
    end
  end

  assign A    = a_q;
  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : ca3_serial_demux_16
`default_nettype wire

// File: tb/tb_ca3_serial_demux_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ca3_serial_demux_16 : directed self-checking bench.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_ca3_serial_demux_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        din;
  logic        din_valid;
  logic        addr_mode;
  logic [3:0]  S;
  logic [15:0] A;
  logic        busy;
  logic        done;
  logic [3:0]  cnt;

  int checks   = 0;
  int failures = 0;

  ca3_serial_demux_16 #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .addr_mode (addr_mode),
    .S         (S),
    .A         (A),
    .busy      (busy),
    .done      (done),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic mode, input logic [3:0] s);
    din       = b;
    din_valid = 1'b1;
    addr_mode = mode;
    S         = s;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [15:0] word;
  int          done_seen;
  int          busy_low;
  int          cnt_bad;

  initial begin
    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; addr_mode = 1'b0; S = 4'd0;
    tick(); tick();
    chk("rst_A", A, 16'h0000);
    chk("rst_cnt", {12'd0, cnt}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    rst = 1'b0;
    tick();

    // Auto-increment frame of A5C3, LSB first
    word = 16'hA5C3;
    do_start();
    chk("start_busy", {15'd0, busy}, 16'd1);
    chk("start_cnt", {12'd0, cnt}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      send_bit(word[i], 1'b0, 4'd0);
      if (i == 7)  chk("auto_half_A", A, 16'h00C3);
      if (i == 14) begin
        chk("auto_15_cnt", {12'd0, cnt}, 16'd15);
        chk("auto_15_done", {15'd0, done}, 16'd0);
      end
    end
    chk("auto_done", {15'd0, done}, 16'd1);
    chk("auto_A", A, 16'hA5C3);
    chk("auto_cnt", {12'd0, cnt}, 16'd0);
    chk("auto_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("auto_done_pulse", {15'd0, done}, 16'd0);
    chk("auto_idle_A", A, 16'hA5C3);

    // Same frame with a gap cycle before every bit
    do_start();
    done_seen = 0; busy_low = 0; cnt_bad = 0;
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b0;
      din = ~word[i];
      tick();
      if (!busy) busy_low++;
      if (done) done_seen++;
      if (cnt != i[3:0]) cnt_bad++;
      send_bit(word[i], 1'b0, 4'd0);
      if (i < 15 && !busy) busy_low++;
      if (done) done_seen++;
    end
    tick();
    if (done) done_seen++;
    chk("gap_A", A, 16'hA5C3);
    chk("gap_done_once", done_seen[15:0], 16'd1);
    chk("gap_busy_low", busy_low[15:0], 16'd0);
    chk("gap_cnt_hold", cnt_bad[15:0], 16'd0);

    // Addressed mode, S from 15 down to 0
    do_start();
    for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b1, 4'(15 - i));
    chk("addr_desc_A", A, 16'hFFFF);
    chk("addr_desc_done", {15'd0, done}, 16'd1);
    tick();

    // Addressed mode, S fixed at 3
    do_start();
    chk("addr_clear_A", A, 16'h0000);
    for (int i = 0; i < 15; i++) send_bit(1'b1, 1'b1, 4'd3);
    chk("addr_fix_15_done", {15'd0, done}, 16'd0);
    send_bit(1'b1, 1'b1, 4'd3);
    chk("addr_fix_A", A, 16'h0008);
    chk("addr_fix_done", {15'd0, done}, 16'd1);
    tick();

    // Mode switch mid-frame: 8 auto bits of 1, then 8 addressed zeros to bit 15
    do_start();
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0, 4'd15);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 4'd15);
    chk("mix_A", A, 16'h00FF);
    chk("mix_done", {15'd0, done}, 16'd1);
    tick();

    // Asynchronous reset after 7 bits
    word = 16'h1234;
    do_start();
    for (int i = 0; i < 7; i++) send_bit(word[i], 1'b0, 4'd0);
    chk("pre_rst_cnt", {12'd0, cnt}, 16'd7);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_A", A, 16'h0000);
    chk("mid_rst_cnt", {12'd0, cnt}, 16'd0);
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_idle", {15'd0, busy}, 16'd0);
    do_start();
    for (int i = 0; i < 16; i++) send_bit(word[i], 1'b0, 4'd0);
    chk("post_rst_A", A, 16'h1234);
    chk("post_rst_done", {15'd0, done}, 16'd1);
    tick();

    // din_valid in IDLE is ignored
    din = 1'b1; din_valid = 1'b1;
    tick(); tick(); tick();
    din_valid = 1'b0;
    chk("idle_valid_A", A, 16'h1234);
    chk("idle_valid_cnt", {12'd0, cnt}, 16'd0);
    chk("idle_valid_busy", {15'd0, busy}, 16'd0);
    chk("idle_valid_done", {15'd0, done}, 16'd0);

    // start during RECV and DONE is ignored
    word = 16'h5A0F;
    do_start();
    for (int i = 0; i < 5; i++) send_bit(word[i], 1'b0, 4'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("recv_start_cnt", {12'd0, cnt}, 16'd5);
    chk("recv_start_A", A, 16'h000F);
    chk("recv_start_busy", {15'd0, busy}, 16'd1);
    for (int i = 5; i < 16; i++) send_bit(word[i], 1'b0, 4'd0);
    chk("ign_done", {15'd0, done}, 16'd1);
    chk("ign_A", A, 16'h5A0F);
    start = 1'b1; din_valid = 1'b1; din = 1'b0;
    tick();
    start = 1'b0; din_valid = 1'b0;
    chk("done_start_busy", {15'd0, busy}, 16'd0);
    chk("done_start_done", {15'd0, done}, 16'd0);
    chk("done_start_A", A, 16'h5A0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ca3_serial_demux_16
`default_nettype wire

// File: doc/ca3_serial_demux_16.md
CA3_SERIAL_DEMUX_16 -- requirements
Module: ca3_serial_demux_16

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the output word width; only 16 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, which begins a frame when sampled high in IDLE.
REQ-005 The block SHALL have port din, input, 1 bit, the serial data bit.
REQ-006 The block SHALL have port din_valid, input, 1 bit; din is accepted on an edge where din_valid=1 in RECV.
REQ-007 The block SHALL have port addr_mode, input, 1 bit: 0 selects auto-increment position, 1 selects explicit position from S.
REQ-008 The block SHALL have port S, input, 4 bits, the explicit write position, used only when addr_mode=1.
REQ-009 The block SHALL have port A, output, 16 bits, the reassembled word.
REQ-010 The block SHALL have port busy, output, 1 bit, high while in RECV.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse when the frame completes.
REQ-012 The block SHALL have port cnt, output, 4 bits, the number of bits accepted so far in the frame (mod 16).

Function
REQ-013 The block SHALL implement FSM states IDLE, RECV and DONE, with all outputs registered.
REQ-014 In IDLE, start=1 SHALL move the FSM to RECV, clear cnt to 0 and clear A to 16'h0000.
REQ-015 In RECV, an accepted bit SHALL write A[cnt]<=din when addr_mode=0, or A[S]<=din when addr_mode=1, and SHALL increment cnt by 1.
REQ-016 Only the addressed bit of A SHALL change per accepted bit; all other bits SHALL hold.
REQ-017 When the accepted bit arrives with cnt=15, the FSM SHALL move to DONE and cnt SHALL wrap to 0.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-019 done SHALL be high in the cycle immediately after the edge that accepted the 16th bit, with A final in that same cycle.
REQ-020 A SHALL hold its value in IDLE until the next accepted start.
REQ-021 A cycle in RECV with din_valid=0 SHALL change nothing.
REQ-022 din_valid SHALL be ignored in IDLE and DONE, and start SHALL be ignored in RECV and DONE.
REQ-023 In addressed mode, repeated S values SHALL overwrite, positions never addressed SHALL remain 0, and the frame SHALL still end after 16 accepted bits.
REQ-024 addr_mode and S SHALL be sampled per accepted bit, so switching modes mid-frame is legal.
REQ-025 busy SHALL be 1 exactly when the state is RECV.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, A=16'h0000, cnt=0, busy=0 and done=0.
REQ-027 rst asserted mid-frame SHALL discard the partial word; after release, the block SHALL wait in IDLE for start.

Structure
REQ-028 A shared package ca3_demux_pkg SHALL hold the FSM state enum (IDLE, RECV, DONE) and the constants N=16 and SW=4.
REQ-029 Write-enable generation SHALL use a sub-module ca3_demux_1to4 (1-to-4 decoder with enable), instantiated five times as a two-level tree to form the 16 one-hot bit enables.

Verification
REQ-030 Auto mode: start, then 16 valid bits LSB-first of 16'hA5C3 -> done one cycle after the 16th bit, A=16'hA5C3, cnt=0, busy=0.
REQ-031 Gaps: the same frame with din_valid=0 on every other cycle -> A=16'hA5C3, done exactly once, busy high for the full 32 cycles.
REQ-032 Addressed mode: 16 bits of din=1 with S=15 down to 0 -> A=16'hFFFF; 16 bits of din=1 with S fixed at 3 -> A=16'h0008.
REQ-033 Reset mid-frame: assert rst after 7 bits -> A=0, cnt=0, IDLE immediately; a following full frame of 16'h1234 -> A=16'h1234.
REQ-034 Ignored inputs: start pulsed during RECV and din_valid=1 in IDLE -> no state, cnt or A change, and no extra done.
